// File: rtl/mem_ctrl.sv
// Memory access controller: turns sequencer fetch/EXE states into single memory requests and captures the read data.
// Optional abort-on-timeout with a sticky err flag when MEM_CTRL_TIMEOUT_EN is defined.
module mem_ctrl #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int TMO = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    q,
   input  logic [AW-1:0] pc,
   input  logic [AW-1:0] opadr,
   input  logic          ld,
   input  logic          st,
   input  logic [DW-1:0] wdata,
   input  logic          ack,
   input  logic [DW-1:0] rdata,
   output logic          kp,
   output logic          mreq,
   output logic          mwe,
   output logic [AW-1:0] maddr,
   output logic [DW-1:0] mwdata,
   output logic [DW-1:0] opc,
   output logic [DW-1:0] opl,
   output logic [DW-1:0] dat,
   output logic          err
);

   // state | meaning
   // M_IDLE | no access outstanding, watching q for a start
   // M_BUSY | request on the bus, waiting for ack (or timeout)

   // Shared sequencer codes: IDLE=0 OPCFT=1 OPLRD=2 OPLFT=3 ADRD=4 EXERD=5 EXE=6 LDRD=7 LOAD=8
   localparam logic [3:0] Q_OPCFT = 4'd1;
   localparam logic [3:0] Q_OPLFT = 4'd3;
   localparam logic [3:0] Q_EXE   = 4'd6;

   typedef enum logic {M_IDLE, M_BUSY} mstate_t;
   typedef enum logic [1:0] {D_OPC, D_OPL, D_DAT} dest_t;

   mstate_t state;
   dest_t   dest;

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
   logic [CW-1:0] cnt;
   logic          err_r;
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= M_IDLE;
         dest   <= D_OPC;
         kp     <= 1'b0;
         mreq   <= 1'b0;
         mwe    <= 1'b0;
         maddr  <= '0;
         mwdata <= '0;
         opc    <= '0;
         opl    <= '0;
         dat    <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
         cnt    <= '0;
         err_r  <= 1'b0;
`endif
      end else begin
         case (state)
            M_IDLE: begin
               if (q == Q_OPCFT || q == Q_OPLFT || (q == Q_EXE && (ld || st))) begin
                  state <= M_BUSY;
                  kp    <= 1'b1;
                  mreq  <= 1'b1;
`ifdef MEM_CTRL_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
               if (q == Q_OPCFT) begin
                  maddr <= pc;
                  mwe   <= 1'b0;
                  dest  <= D_OPC;
               end else if (q == Q_OPLFT) begin
                  maddr <= pc + AW'(1);
                  mwe   <= 1'b0;
                  dest  <= D_OPL;
               end else if (q == Q_EXE && ld) begin
                  maddr <= opadr;
                  mwe   <= 1'b0;
                  dest  <= D_DAT;
               end else if (q == Q_EXE && st) begin
                  maddr  <= opadr;
                  mwe    <= 1'b1;
                  mwdata <= wdata;
                  dest   <= D_DAT;
               end
            end
            M_BUSY: begin
               if (ack) begin
                  if (!mwe) begin
                     case (dest)
                        D_OPC:   opc <= rdata;
                        D_OPL:   opl <= rdata;
                        default: dat <= rdata;
                     endcase
                  end
                  state <= M_IDLE;
                  kp    <= 1'b0;
                  mreq  <= 1'b0;
                  mwe   <= 1'b0;
               end
`ifdef MEM_CTRL_TIMEOUT_EN
               // abort once TMO busy cycles have gone by without ack
               else if (cnt == CW'(TMO - 1)) begin
                  if (!mwe) begin
                     case (dest)
                        D_OPC:   opc <= '1;
                        D_OPL:   opl <= '1;
                        default: dat <= '1;
                     endcase
                  end
                  state <= M_IDLE;
                  kp    <= 1'b0;
                  mreq  <= 1'b0;
                  mwe   <= 1'b0;
                  err_r <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
`endif
            end
            default: state <= M_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected completions, a monitor checks them as ack finishes each access.
module tb_mem_ctrl;
   localparam logic [3:0] Q_IDLE = 4'd0, Q_OPCFT = 4'd1, Q_OPLRD = 4'd2, Q_OPLFT = 4'd3,
                          Q_ADRD = 4'd4, Q_EXERD = 4'd5, Q_EXE = 4'd6, Q_LDRD = 4'd7;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] q = Q_IDLE;
   logic [7:0] pc = '0, opadr = '0, wdata = '0, rdata = '0;
   logic       ld = 1'b0, st = 1'b0, ack = 1'b0;
   logic       kp, mreq, mwe, err;
   logic [7:0] maddr, mwdata, opc, opl, dat;

   mem_ctrl #(.AW(8), .DW(8), .TMO(15)) dut (
      .clk(clk), .rst_n(rst_n), .q(q), .pc(pc), .opadr(opadr), .ld(ld), .st(st),
      .wdata(wdata), .ack(ack), .rdata(rdata), .kp(kp), .mreq(mreq), .mwe(mwe),
      .maddr(maddr), .mwdata(mwdata), .opc(opc), .opl(opl), .dat(dat), .err(err));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] maddr;
      logic       mwe;
      logic [7:0] mwdata, opc, opl, dat;
      int         kp_cycles;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input logic [7:0] a, input logic w, input logic [7:0] wd,
                       input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] d, input int k);
      exp_t e;
      e.maddr = a; e.mwe = w; e.mwdata = wd; e.opc = o1; e.opl = o2; e.dat = d; e.kp_cycles = k;
      exp_q.push_back(e);
   endtask

   // monitor: count kp cycles, and on each ack-completed access compare against the queue head
   initial begin
      int kpc;
      exp_t e;
      logic [7:0] a_maddr, a_mwdata;
      logic a_mwe;
      kpc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !kp) kpc = 0;
         else kpc++;
         if (rst_n && mreq && ack) begin
            a_maddr = maddr; a_mwe = mwe; a_mwdata = mwdata;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("maddr", 32'(a_maddr), 32'(e.maddr));
               chk("mwe", 32'(a_mwe), 32'(e.mwe));
               chk("mwdata", 32'(a_mwdata), 32'(e.mwdata));
               chk("kp_cycles", 32'(kpc), 32'(e.kp_cycles));
               chk("opc", 32'(opc), 32'(e.opc));
               chk("opl", 32'(opl), 32'(e.opl));
               chk("dat", 32'(dat), 32'(e.dat));
               chk("done_mreq", 32'(mreq), 32'd0);
               chk("done_kp", 32'(kp), 32'd0);
            end
            kpc = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(2);
      chk("rst_kp", 32'(kp), 32'd0);
      chk("rst_mreq", 32'(mreq), 32'd0);
      chk("rst_maddr", 32'(maddr), 32'd0);
      chk("rst_opc", 32'(opc), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      cyc(1);

      // zero-wait opcode fetch
      push(8'h10, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h00, 1);
      pc = 8'h10; q = Q_OPCFT; ack = 1'b1; rdata = 8'h3C;
      cyc(1);
      chk("fetch_kp_next", 32'(kp), 32'd1);
      q = Q_OPLRD;
      cyc(1);
      ack = 1'b0; q = Q_IDLE;
      cyc(1);

      // operand fetch with address wrap, 3-cycle access, overlapping OPCFT ignored
      push(8'h00, 1'b0, 8'h00, 8'h3C, 8'h55, 8'h00, 3);
      pc = 8'hFF; q = Q_OPLFT; rdata = 8'h55;
      cyc(1);
      q = Q_OPCFT; pc = 8'h20;
      cyc(2);
      chk("busy_maddr_hold", 32'(maddr), 32'h00);
      q = Q_IDLE; ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      cyc(1);
      chk("no_queued_start", 32'(mreq), 32'd0);

      // store, 2-cycle access
      push(8'h80, 1'b1, 8'hA5, 8'h3C, 8'h55, 8'h00, 2);
      q = Q_EXE; st = 1'b1; opadr = 8'h80; wdata = 8'hA5; rdata = 8'hCC;
      cyc(1);
      q = Q_EXERD; st = 1'b0;
      cyc(1);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0; q = Q_IDLE;
      cyc(1);

      // ld and st together behave as a load
      push(8'h42, 1'b0, 8'hA5, 8'h3C, 8'h55, 8'h77, 1);
      q = Q_EXE; ld = 1'b1; st = 1'b1; opadr = 8'h42; wdata = 8'h99; rdata = 8'h77; ack = 1'b1;
      cyc(1);
      q = Q_LDRD; ld = 1'b0; st = 1'b0;
      cyc(1);
      ack = 1'b0; q = Q_IDLE;
      cyc(1);

      // EXE with neither ld nor st, then ack while idle: nothing happens
      q = Q_EXE;
      cyc(2);
      chk("exe_none_mreq", 32'(mreq), 32'd0);
      q = Q_IDLE; ack = 1'b1; rdata = 8'hEE;
      cyc(2);
      chk("idle_ack_dat", 32'(dat), 32'h77);
      ack = 1'b0;

      // reset in the middle of a load
      q = Q_EXE; ld = 1'b1; opadr = 8'h33;
      cyc(1);
      q = Q_IDLE; ld = 1'b0;
      chk("midload_mreq", 32'(mreq), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mreq", 32'(mreq), 32'd0);
      chk("rst_mid_kp", 32'(kp), 32'd0);
      chk("rst_mid_dat", 32'(dat), 32'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      chk("no_resume_mreq", 32'(mreq), 32'd0);
      chk("no_resume_kp", 32'(kp), 32'd0);

`ifdef MEM_CTRL_TIMEOUT_EN
      q = Q_EXE; ld = 1'b1; opadr = 8'h10;
      cyc(1);
      q = Q_IDLE; ld = 1'b0;
      cyc(14);
      chk("tmo_still_busy", 32'(kp), 32'd1);
      cyc(1);
      chk("tmo_kp", 32'(kp), 32'd0);
      chk("tmo_dat", 32'(dat), 32'hFF);
      chk("tmo_err", 32'(err), 32'd1);
      push(8'h21, 1'b0, 8'h00, 8'h5A, 8'h00, 8'hFF, 1);
      pc = 8'h21; q = Q_OPCFT; ack = 1'b1; rdata = 8'h5A;
      cyc(1);
      q = Q_OPLRD;
      cyc(1);
      ack = 1'b0; q = Q_IDLE;
      cyc(1);
      chk("tmo_err_sticky", 32'(err), 32'd1);
`else
      chk("err_tied_low", 32'(err), 32'd0);
`endif

      cyc(2);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
